// File: rtl/acc_offload_issue.sv
// rtl/acc_offload_issue.sv - offload issue stage: hazard stall, operand build, 2-entry skid buffer
package acc_offload_pkg;
  typedef enum logic {OP_RS = 1'b0, OP_IMM = 1'b1} op_sel_e;
  typedef enum logic [1:0] {IMM_I = 2'd0, IMM_S = 2'd1, IMM_U = 2'd2} imm_sel_e;

  typedef struct packed {
    logic [31:0] q_instr_data;
  } prd_req_t;

  typedef struct packed {
    logic       p_accept;
    logic [1:0] p_writeback;
    logic [2:0] p_use_rs;
    op_sel_e    p_op_a_mux;
    op_sel_e    p_op_b_mux;
    op_sel_e    p_op_c_mux;
    imm_sel_e   p_imm_a_mux;
    imm_sel_e   p_imm_b_mux;
    imm_sel_e   p_imm_c_mux;
  } prd_rsp_t;
endpackage

module acc_offload_issue
  import acc_offload_pkg::*;
#(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   core_q_valid_i,
  output logic                   core_q_ready_o,
  input  logic [31:0]            core_q_instr_i,
  input  logic [3*DataWidth-1:0] core_q_rs_i,
  input  logic [2:0]             core_q_rs_valid_i,
  output logic                   core_k_accept_o,
  output logic                   core_k_writeback_o,
  output prd_req_t               prd_req_o,
  input  prd_rsp_t               prd_rsp_i,
  output logic                   acc_q_valid_o,
  input  logic                   acc_q_ready_i,
  output logic [31:0]            acc_q_instr_o,
  output logic [3*DataWidth-1:0] acc_q_op_o,
  input  logic                   acc_wb_done_i
);
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  typedef struct packed {
    logic [31:0]            instr;
    logic [3*DataWidth-1:0] op;
  } entry_t;

  entry_t              mem_q [2];
  logic                rd_ptr_q;
  logic                wr_ptr_q;
  logic [1:0]          fill_q;
  logic [CntWidth-1:0] cnt_q;

  logic   wb;
  logic   rs_ok;
  logic   full;
  logic   push;
  logic   pop;
  logic   inc;
  logic   dec;
  entry_t new_entry;

  // Immediates are decoded from the instruction; a register operand passes rs unchanged.
  function automatic logic [DataWidth-1:0] build_op(input op_sel_e sel, input imm_sel_e imm,
                                                    input logic [DataWidth-1:0] rs,
                                                    input logic [31:0] instr);
    logic [DataWidth-1:0] res;
    res = '0;
    unique case (imm)
      IMM_I:   res = DataWidth'(signed'(instr[31:20]));
      IMM_S:   res = DataWidth'(signed'({instr[31:25], instr[11:7]}));
      IMM_U:   res = DataWidth'(signed'({instr[31:12], 12'b0}));
      default: res = '0;
    endcase
    if (sel == OP_RS) res = rs;
    return res;
  endfunction

  assign prd_req_o.q_instr_data = core_q_instr_i;

  assign wb    = prd_rsp_i.p_writeback != 2'b00;
  assign rs_ok = &(~prd_rsp_i.p_use_rs | core_q_rs_valid_i);
  assign full  = fill_q == 2'd2;
  // Fullness is judged before any same-cycle pop so ready never depends on acc_q_ready_i.
  assign push  = core_q_valid_i && prd_rsp_i.p_accept && rs_ok && !full
                 && !(wb && cnt_q == CntMax);
  assign pop   = acc_q_valid_o && acc_q_ready_i;
  assign inc   = push && wb;
  assign dec   = acc_wb_done_i && cnt_q != '0;

  assign core_q_ready_o     = core_q_valid_i && (!prd_rsp_i.p_accept || push);
  assign core_k_accept_o    = push;
  assign core_k_writeback_o = wb;

  assign new_entry.instr = core_q_instr_i;
  assign new_entry.op = {
    build_op(prd_rsp_i.p_op_c_mux, prd_rsp_i.p_imm_c_mux,
             core_q_rs_i[3*DataWidth-1:2*DataWidth], core_q_instr_i),
    build_op(prd_rsp_i.p_op_b_mux, prd_rsp_i.p_imm_b_mux,
             core_q_rs_i[2*DataWidth-1:DataWidth], core_q_instr_i),
    build_op(prd_rsp_i.p_op_a_mux, prd_rsp_i.p_imm_a_mux,
             core_q_rs_i[DataWidth-1:0], core_q_instr_i)
  };

  assign acc_q_valid_o = fill_q != 2'd0;
  assign acc_q_instr_o = mem_q[rd_ptr_q].instr;
  assign acc_q_op_o    = mem_q[rd_ptr_q].op;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      fill_q   <= 2'd0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= new_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      fill_q <= fill_q + 2'(push) - 2'(pop);
      if (inc && !dec) cnt_q <= cnt_q + 1'b1;
      else if (dec && !inc) cnt_q <= cnt_q - 1'b1;
    end
  end

  a_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    acc_q_valid_o && !acc_q_ready_i |=> $stable(acc_q_instr_o) && $stable(acc_q_op_o));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> !full);
  a_wb_done_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    acc_wb_done_i |-> cnt_q != '0);
endmodule

// File: tb/tb_acc_offload_issue.sv
// tb/tb_acc_offload_issue.sv - scoreboard bench for acc_offload_issue
module tb_acc_offload_issue;
  import acc_offload_pkg::*;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          core_q_valid_i;
  logic          core_q_ready_o;
  logic [31:0]   core_q_instr_i;
  logic [3*DW-1:0] core_q_rs_i;
  logic [2:0]    core_q_rs_valid_i;
  logic          core_k_accept_o;
  logic          core_k_writeback_o;
  prd_req_t      prd_req_o;
  prd_rsp_t      prd_rsp_i;
  logic          acc_q_valid_o;
  logic          acc_q_ready_i;
  logic [31:0]   acc_q_instr_o;
  logic [3*DW-1:0] acc_q_op_o;
  logic          acc_wb_done_i;

  int checks = 0;
  int errors = 0;
  logic [127:0] sb [$];

  acc_offload_issue #(.DataWidth(DW), .MaxOutstanding(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_q_valid_i(core_q_valid_i), .core_q_ready_o(core_q_ready_o),
    .core_q_instr_i(core_q_instr_i), .core_q_rs_i(core_q_rs_i),
    .core_q_rs_valid_i(core_q_rs_valid_i), .core_k_accept_o(core_k_accept_o),
    .core_k_writeback_o(core_k_writeback_o), .prd_req_o(prd_req_o), .prd_rsp_i(prd_rsp_i),
    .acc_q_valid_o(acc_q_valid_o), .acc_q_ready_i(acc_q_ready_i),
    .acc_q_instr_o(acc_q_instr_o), .acc_q_op_o(acc_q_op_o), .acc_wb_done_i(acc_wb_done_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic prd_rsp_t mk(input logic acc, input logic [1:0] wbk, input logic [2:0] use_rs,
                                  input op_sel_e a, input op_sel_e b, input op_sel_e c,
                                  input imm_sel_e ia, input imm_sel_e ib, input imm_sel_e ic);
    prd_rsp_t r;
    r.p_accept    = acc;
    r.p_writeback = wbk;
    r.p_use_rs    = use_rs;
    r.p_op_a_mux  = a;
    r.p_op_b_mux  = b;
    r.p_op_c_mux  = c;
    r.p_imm_a_mux = ia;
    r.p_imm_b_mux = ib;
    r.p_imm_c_mux = ic;
    return r;
  endfunction

  task automatic drive(input logic [31:0] instr, input prd_rsp_t rsp, input logic [3*DW-1:0] rs,
                       input logic [2:0] rsv);
    core_q_valid_i    = 1'b1;
    core_q_instr_i    = instr;
    prd_rsp_i         = rsp;
    core_q_rs_i       = rs;
    core_q_rs_valid_i = rsv;
  endtask

  // Checks the handshake of the current cycle and books the expected issue on acceptance.
  task automatic expect_hs(input string name, input logic er, input logic ea, input logic ew,
                           input logic ev, input logic [31:0] instr, input logic [3*DW-1:0] op);
    @(negedge clk_i);
    check({name, "_ready"}, 128'(core_q_ready_o), 128'(er));
    check({name, "_acc_valid"}, 128'(acc_q_valid_o), 128'(ev));
    if (er) check({name, "_accept"}, 128'(core_k_accept_o), 128'(ea));
    if (er && ea) begin
      check({name, "_writeback"}, 128'(core_k_writeback_o), 128'(ew));
      sb.push_back({instr, op});
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input string name, input logic ev);
    core_q_valid_i = 1'b0;
    @(negedge clk_i);
    check({name, "_acc_valid"}, 128'(acc_q_valid_o), 128'(ev));
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin : monitor
    logic [127:0] e;
    if (rst_ni && acc_q_valid_o && acc_q_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got instr %0h expected none", acc_q_instr_o);
      end else begin
        e = sb.pop_front();
        check("issue_instr", 128'(acc_q_instr_o), 128'(e[127:96]));
        check("issue_ops", 128'(acc_q_op_o), 128'(e[95:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    prd_rsp_t rs_only;
    prd_rsp_t rs_wb;
    logic [3*DW-1:0] rs;
    rs_only = mk(1'b1, 2'b00, 3'b000, OP_RS, OP_RS, OP_RS, IMM_I, IMM_I, IMM_I);
    rs_wb   = mk(1'b1, 2'b01, 3'b000, OP_RS, OP_RS, OP_RS, IMM_I, IMM_I, IMM_I);
    rst_ni = 1'b0;
    core_q_valid_i = 1'b0;
    core_q_instr_i = '0;
    core_q_rs_i = '0;
    core_q_rs_valid_i = '0;
    prd_rsp_i = '0;
    acc_q_ready_i = 1'b1;
    acc_wb_done_i = 1'b0;

    @(negedge clk_i);
    check("rst_acc_valid", 128'(acc_q_valid_o), 128'(0));
    check("rst_core_ready", 128'(core_q_ready_o), 128'(0));
    check("rst_acc_instr", 128'(acc_q_instr_o), 128'(0));
    check("rst_acc_op", 128'(acc_q_op_o), 128'(0));
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Illegal instruction is consumed and dropped
    drive(32'hFFFF_FFFF, mk(1'b0, 2'b00, 3'b111, OP_RS, OP_RS, OP_RS, IMM_I, IMM_I, IMM_I),
          '0, 3'b111);
    expect_hs("t1_reject", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    idle("t1_nothing_issued", 1'b0);

    // I-type immediate all ones sign-extends; predecoder sees the raw word
    drive(32'hFFF0_8093, mk(1'b1, 2'b00, 3'b001, OP_RS, OP_IMM, OP_RS, IMM_I, IMM_I, IMM_I),
          {32'h33, 32'h22, 32'h5}, 3'b111);
    check("t2_prd_req", 128'(prd_req_o.q_instr_data), 128'(32'hFFF0_8093));
    expect_hs("t2_accept", 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFF0_8093,
              {32'h33, 32'hFFFF_FFFF, 32'h5});
    idle("t2_latency", 1'b1);

    // rs2 hazard for three cycles; operands use S and U immediates
    drive(32'h8000_0F80, mk(1'b1, 2'b00, 3'b010, OP_IMM, OP_RS, OP_IMM, IMM_S, IMM_I, IMM_U),
          {32'hCCCC_CCCC, 32'h1234_5678, 32'hAAAA_AAAA}, 3'b101);
    for (int i = 0; i < 3; i++)
      expect_hs("t3_hazard", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '0);
    core_q_rs_valid_i = 3'b111;
    expect_hs("t3_go", 1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0F80,
              {32'h8000_0000, 32'h1234_5678, 32'hFFFF_F81F});
    idle("t3_issue", 1'b1);

    // Backpressure: two entries fill the skid buffer, third waits, drain in order
    acc_q_ready_i = 1'b0;
    drive(32'h0000_1001, rs_only, {32'h301, 32'h201, 32'h101}, 3'b111);
    expect_hs("t4_x1", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1001, {32'h301, 32'h201, 32'h101});
    drive(32'h7FF0_0002, mk(1'b1, 2'b00, 3'b000, OP_RS, OP_IMM, OP_RS, IMM_I, IMM_I, IMM_I),
          {32'h302, 32'h202, 32'h102}, 3'b111);
    expect_hs("t4_x2", 1'b1, 1'b1, 1'b0, 1'b1, 32'h7FF0_0002, {32'h302, 32'h7FF, 32'h102});
    drive(32'h7FFF_F0AB, mk(1'b1, 2'b00, 3'b000, OP_RS, OP_RS, OP_IMM, IMM_I, IMM_I, IMM_U),
          {32'h303, 32'h203, 32'h103}, 3'b111);
    expect_hs("t4_x3_full", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, '0);
    acc_q_ready_i = 1'b1;
    expect_hs("t4_x3_prepop", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, '0);
    expect_hs("t4_x3", 1'b1, 1'b1, 1'b0, 1'b1, 32'h7FFF_F0AB, {32'h7FFF_F000, 32'h203, 32'h103});
    idle("t4_drain", 1'b1);
    idle("t4_empty", 1'b0);

    // Outstanding writeback limit
    for (int k = 0; k < 4; k++) begin
      rs = {32'(32'h30 + k), 32'(32'h20 + k), 32'(32'h10 + k)};
      drive(32'(32'h2000 + k), rs_wb, rs, 3'b111);
      expect_hs("t5_fill", 1'b1, 1'b1, 1'b1, k != 0, 32'(32'h2000 + k), rs);
    end
    drive(32'h0000_2004, rs_wb, {32'h34, 32'h24, 32'h14}, 3'b111);
    expect_hs("t5_limit", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, '0);
    expect_hs("t5_limit", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, '0);
    acc_wb_done_i = 1'b1;
    expect_hs("t5_limit_done", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, '0);
    expect_hs("t5_inc_dec", 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_2004, {32'h34, 32'h24, 32'h14});
    acc_wb_done_i = 1'b0;
    drive(32'h0000_2005, rs_wb, {32'h35, 32'h25, 32'h15}, 3'b111);
    expect_hs("t5_refill", 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_2005, {32'h35, 32'h25, 32'h15});
    drive(32'h0000_2006, rs_wb, {32'h36, 32'h26, 32'h16}, 3'b111);
    expect_hs("t5_full_again", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, '0);
    idle("t5_empty", 1'b0);

    // Reset with two buffered entries
    acc_q_ready_i = 1'b0;
    drive(32'h0000_3001, rs_only, {32'h41, 32'h42, 32'h43}, 3'b111);
    expect_hs("t6_y1", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_3001, {32'h41, 32'h42, 32'h43});
    drive(32'h0000_3002, rs_only, {32'h51, 32'h52, 32'h53}, 3'b111);
    expect_hs("t6_y2", 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_3002, {32'h51, 32'h52, 32'h53});
    core_q_valid_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    check("t6_rst_valid", 128'(acc_q_valid_o), 128'(0));
    check("t6_rst_instr", 128'(acc_q_instr_o), 128'(0));
    check("t6_rst_op", 128'(acc_q_op_o), 128'(0));
    sb.delete();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    acc_q_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rs = {32'(32'h60 + k), 32'(32'h70 + k), 32'(32'h80 + k)};
      drive(32'(32'h4000 + k), rs_wb, rs, 3'b111);
      expect_hs("t6_cnt_cleared", 1'b1, 1'b1, 1'b1, k != 0, 32'(32'h4000 + k), rs);
    end
    drive(32'h0000_4004, rs_wb, {32'h64, 32'h74, 32'h84}, 3'b111);
    expect_hs("t6_limit", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, '0);
    idle("t6_empty", 1'b0);
    check("sb_drained", 128'(sb.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
